// File: rtl/kvt_scfifo_param.sv
// Single-clock FIFO with occupancy count, registered threshold flags, sticky
// overflow/underflow and an optional first-word-fall-through output.
module kvt_scfifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned SHOWAHEAD = 0,
  parameter int unsigned AF_LVL    = DEPTH - 2,
  parameter int unsigned AE_LVL    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sclr,
  input  logic                     wrreq,
  input  logic [DATA_W-1:0]        data,
  input  logic                     rdreq,
  output logic [DATA_W-1:0]        q,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("kvt_scfifo_param: DEPTH must be a power of 2 and >= 4");
    end
    if (AE_LVL >= AF_LVL) begin : g_bad_ae
      $error("kvt_scfifo_param: AE_LVL must be below AF_LVL");
    end
    if (AF_LVL > DEPTH) begin : g_bad_af
      $error("kvt_scfifo_param: AF_LVL must not exceed DEPTH");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     usedw_q, usedw_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;

  // Acceptance is judged against the flags registered before this edge.
  assign wr_acc = wrreq & ~full_q & ~sclr;
  assign rd_acc = rdreq & ~empty_q & ~sclr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    q_d      = q_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      q_d      = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      usedw_d = usedw_q + CW'(wr_acc) - CW'(rd_acc);
      ovf_d   = ovf_q | (wrreq & full_q);
      unf_d   = unf_q | (rdreq & empty_q);
      if (SHOWAHEAD != 0) begin
        // Preload the next head; with one word left the new head is the word being written.
        if (rd_acc) begin
          if (usedw_q == CW'(1)) q_d = wr_acc ? data : q_q;
          else                   q_d = mem[rd_ptr_q + AW'(1)];
        end else if (wr_acc && empty_q) begin
          q_d = data;
        end
      end else if (rd_acc) begin
        q_d = mem[rd_ptr_q];
      end
    end
    full_d   = (usedw_d == CW'(DEPTH));
    empty_d  = (usedw_d == '0);
    afull_d  = (usedw_d >= CW'(AF_LVL));
    aempty_d = (usedw_d <= CW'(AE_LVL));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      q_q      <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      q_q      <= q_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array carries no reset; occupancy tracking makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= data;
  end

  assign q            = q_q;
  assign usedw        = usedw_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_kvt_scfifo_param.sv
// Scoreboard bench for kvt_scfifo_param: a normal-mode and a showahead instance
// share stimulus; a queue model predicts flags and popped words.
module tb_kvt_scfifo_param;

  logic       clk = 1'b0;
  logic       reset, sclr, wrreq, rdreq;
  logic [7:0] data;
  logic [7:0] q, sa_q;
  logic [4:0] usedw, sa_usedw;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic       sa_full, sa_empty, sa_afull, sa_aempty, sa_ovf, sa_unf;

  always #5 clk = ~clk;

  kvt_scfifo_param #(.DATA_W(8), .DEPTH(16), .SHOWAHEAD(0), .AF_LVL(14), .AE_LVL(2)) u_dut (
    .clk(clk), .reset(reset), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q), .usedw(usedw), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow));

  kvt_scfifo_param #(.DATA_W(8), .DEPTH(16), .SHOWAHEAD(1), .AF_LVL(14), .AE_LVL(2)) u_sa (
    .clk(clk), .reset(reset), .sclr(sclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(sa_q), .usedw(sa_usedw), .full(sa_full), .empty(sa_empty), .almost_full(sa_afull),
    .almost_empty(sa_aempty), .overflow(sa_ovf), .underflow(sa_unf));

  int         total = 0;
  int         bad = 0;
  logic [7:0] mdl[$];
  logic [7:0] exp_q[$];
  bit         ovf_m, unf_m;
  bit         pop_pend, clr_pend;
  logic [7:0] q_cur;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic chk();
    int n;
    n = mdl.size();
    cmp("usedw", usedw, n);
    cmp("full", full, n == 16);
    cmp("empty", empty, n == 0);
    cmp("almost_full", almost_full, n >= 14);
    cmp("almost_empty", almost_empty, n <= 2);
    cmp("overflow", overflow, ovf_m);
    cmp("underflow", underflow, unf_m);
    cmp("sa_usedw", sa_usedw, n);
    cmp("sa_empty", sa_empty, n == 0);
    if (n > 0) cmp("sa_head", sa_q, mdl[0]);
  endtask

  // One clock of stimulus; model updated from the pre-edge occupancy.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
    int n;
    bit wa, ra;
    wrreq = w; data = d; rdreq = r; sclr = c;
    @(posedge clk);
    n  = mdl.size();
    wa = w && (n < 16) && !c;
    ra = r && (n > 0) && !c;
    if (c) begin
      mdl.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      ovf_m = ovf_m | (w && n == 16);
      unf_m = unf_m | (r && n == 0);
    end
    if (ra) exp_q.push_back(mdl.pop_front());
    if (wa) mdl.push_back(d);
    #1;
    wrreq = 1'b0; rdreq = 1'b0; sclr = 1'b0;
    chk();
  endtask

  // Monitor: note pops the DUT performs, then check q against the scoreboard.
  always @(posedge clk) begin
    pop_pend = !reset && rdreq && !empty && !sclr;
    clr_pend = !reset && sclr;
  end

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      q_cur = 8'h00;
    end else begin
      cmp("sb_level", exp_q.size(), pop_pend ? 1 : 0);
      if (exp_q.size() > 0) q_cur = exp_q.pop_front();
      if (clr_pend) q_cur = 8'h00;
      cmp("q", q, q_cur);
    end
  end

  initial begin
    reset = 1'b1; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
    repeat (2) @(negedge clk);
    chk();
    cmp("q_reset", q, 8'h00);
    #1 reset = 1'b0;

    // Fill and drain
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow, full-with-both, drain, underflow, clear
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Clear with contents present
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'h2F, 1'b1, 1'b1);

    // Simultaneous access at usedw=5 across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Showahead head word
    step(1'b1, 8'h5C, 1'b0, 1'b0);
    cmp("sa_first_word", sa_q, 8'h5C);
    cmp("sa_not_empty", sa_empty, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    cmp("sa_empty_after_pop", sa_empty, 1'b1);

    // Async reset at usedw=9
    for (int i = 0; i < 11; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    cmp("usedw_pre_reset", usedw, 9);
    #2 reset = 1'b1;
    #1;
    cmp("arst_q", q, 8'h00);
    cmp("arst_usedw", usedw, 0);
    cmp("arst_empty", empty, 1'b1);
    cmp("arst_almost_empty", almost_empty, 1'b1);
    cmp("arst_full", full, 1'b0);
    cmp("arst_almost_full", almost_full, 1'b0);
    cmp("arst_overflow", overflow, 1'b0);
    cmp("arst_underflow", underflow, 1'b0);
    mdl.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    chk();
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    cmp("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kvt_scfifo_param.md
KVT_SCFIFO_PARAM -- requirements
Module: kvt_scfifo_param

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- DATA_W, 8, data word width in bits.
- DEPTH, 16, storage depth in words; a power of 2 and >= 4.
- SHOWAHEAD, 0, output mode: 0 = normal registered read, 1 = first-word-fall-through.
- AF_LVL, DEPTH-2, almost_full threshold.
- AE_LVL, 2, almost_empty threshold.
REQ-002 The block SHALL use a single clock and an asynchronous, active-high reset.
REQ-003 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state changes on its rising edge.
- reset, in, 1, asynchronous active-high reset.
- sclr, in, 1, synchronous clear.
- wrreq, in, 1, write request.
- data, in, DATA_W, write data.
- rdreq, in, 1, read request (pop).
- q, out, DATA_W, read data.
- usedw, out, $clog2(DEPTH)+1, occupancy count, 0..DEPTH.
- full, out, 1, usedw == DEPTH.
- empty, out, 1, usedw == 0.
- almost_full, out, 1, usedw >= AF_LVL.
- almost_empty, out, 1, usedw <= AE_LVL.
- overflow, out, 1, sticky: a write was rejected.
- underflow, out, 1, sticky: a read was rejected.
REQ-004 Elaboration SHALL fail if any of these hold:
- DEPTH is not a power of 2, or DEPTH < 4.
- AE_LVL >= AF_LVL.
- AF_LVL > DEPTH.

Function
REQ-005 A write SHALL be accepted iff wrreq=1, full=0 and sclr=0; data is stored at the write pointer, which increments modulo DEPTH.
REQ-006 A read SHALL be accepted iff rdreq=1, empty=0 and sclr=0; the read pointer increments modulo DEPTH.
REQ-007 Acceptance SHALL use the flag values registered before the edge:
- Simultaneous wrreq and rdreq while full: the read is accepted and the write is rejected.
- Simultaneous wrreq and rdreq while empty: the write is accepted and the read is rejected.
REQ-008 On each edge, usedw SHALL become usedw + accepted_write - accepted_read. A simultaneous accepted write and read leaves usedw unchanged.
REQ-009 full, empty, almost_full and almost_empty SHALL be registered and SHALL reflect the new usedw in the same cycle usedw updates.
REQ-010 With SHOWAHEAD=0, q SHALL present the popped word one cycle after an accepted read and SHALL otherwise hold its value.
REQ-011 With SHOWAHEAD=1:
- When empty=0, q SHALL equal the head word in every cycle.
- After a write to an empty FIFO, the head word SHALL be valid in the cycle empty deasserts.
- q is don't-care while empty=1.
REQ-012 overflow SHALL set on the edge where wrreq=1 and full=1 and sclr=0, and SHALL remain set until sclr or reset.
REQ-013 underflow SHALL set on the edge where rdreq=1 and empty=1 and sclr=0, and SHALL remain set until sclr or reset.
REQ-014 A rejected write or read SHALL NOT change the pointers, usedw or stored data.
REQ-015 sclr=1 SHALL take priority over wrreq and rdreq and SHALL, on that edge:
- clear both pointers and usedw;
- set empty and almost_empty; clear full and almost_full;
- clear overflow and underflow;
- clear q to 0 when SHOWAHEAD=0.
REQ-016 Pointer wrap SHALL be transparent: sustained write/read at full rate over more than 2*DEPTH words returns data in order with no loss.
REQ-017 Storage memory SHALL NOT require reset.

Reset
REQ-018 Assertion of reset SHALL immediately, without waiting for a clock edge, force:
- q = 0, usedw = 0;
- empty = 1, almost_empty = 1;
- full = 0, almost_full = 0;
- overflow = 0, underflow = 0;
- both pointers to 0.
REQ-019 Reset release SHALL be synchronous to clk. The first write SHALL be accepted on the first rising edge where reset=0.
REQ-020 Reset asserted mid-operation SHALL discard all contents, and no stale word SHALL be readable afterwards.

Verification
All scenarios use DATA_W=8, DEPTH=16, AF_LVL=14, AE_LVL=2.
REQ-021 Fill and drain: write 0x00..0x0F, then read 16 words. Required response:
- q = 0x00..0x0F in order;
- full=1 at usedw=16; almost_full asserts at usedw=14;
- almost_empty deasserts at usedw=3;
- overflow and underflow stay 0.
REQ-022 Overflow: when full, write 0xAA. Required response:
- usedw stays 16 and overflow=1;
- a subsequent full drain never returns 0xAA.
REQ-023 Underflow: rdreq on an empty FIFO. Required response:
- underflow=1, usedw=0, q unchanged;
- a following sclr clears underflow.
REQ-024 Simultaneous access: at usedw=5, hold wrreq=rdreq=1 for 40 cycles. Required response:
- usedw stays 5;
- data order is preserved across the pointer wrap.
REQ-025 Showahead: with SHOWAHEAD=1, write 0x5C into an empty FIFO. Required response:
- q=0x5C in the cycle empty=0, with no rdreq;
- rdreq pops it and empty=1 on the next cycle.
REQ-026 Async reset: at usedw=9, assert reset between clock edges. Required response:
- outputs take their reset values before the next edge;
- after release, empty=1 and usedw=0.
